// File: rtl/lutram_port_arbiter_if.sv
// lutram_port_arbiter_if: request/response bundle between N_REQ clients and the
// shared LUTRAM port arbiter.
//   req_valid/req_ready/req_we : per-requester handshake and direction
//   req_addr/req_wdata         : packed per-requester payload (slot i at i*W +: W)
//   rsp_valid                  : one-hot, one-cycle response pulse
//   rsp_rdata                  : shared response data bus
// master = client side, slave = arbiter side.
interface lutram_port_arbiter_if #(
    parameter int unsigned D_WIDTH = 8,
    parameter int unsigned A_WIDTH = 5,
    parameter int unsigned N_REQ   = 3
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ-1:0]         req_we;
    logic [N_REQ*A_WIDTH-1:0] req_addr;
    logic [N_REQ*D_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]         rsp_valid;
    logic [D_WIDTH-1:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/lutram_port_arbiter.sv
// lutram_port_arbiter: round-robin arbiter sharing one 1W/1R LUTRAM port among
// N_REQ requesters, one access per clock, read-first, registered one-hot
// tagged responses one cycle after the handshake.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : lutram_port_arbiter_if.slave (request handshakes + responses)
//   busy  : high while the post-reset zero-fill sweep runs
// Build option: define LUTRAM_ARB_INIT_EN to build the INIT state that zero-fills
// the array after every reset; otherwise busy is tied low and RUN is entered
// directly.
module lutram_port_arbiter #(
    parameter int unsigned D_WIDTH = 8,
    parameter int unsigned A_WIDTH = 5,
    parameter int unsigned N_REQ   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lutram_port_arbiter_if.slave  bus,
    output logic                  busy
);
    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned DEPTH = 1 << A_WIDTH;

    logic [D_WIDTH-1:0] ram [DEPTH];

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   cand_c;
    logic [PTR_W-1:0]   grant_idx_c;
    logic [N_REQ-1:0]   grant_c;
    logic               found_c;
    logic               run_c;

    logic               sel_we_c;
    logic [A_WIDTH-1:0] sel_addr_c;
    logic [D_WIDTH-1:0] sel_wdata_c;

    logic               ram_we_c;
    logic [A_WIDTH-1:0] ram_waddr_c;
    logic [D_WIDTH-1:0] ram_wdata_c;

`ifdef LUTRAM_ARB_INIT_EN
    typedef enum logic {
        ST_RUN,
        ST_INIT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [A_WIDTH-1:0] init_cnt;
    logic [A_WIDTH-1:0] init_cnt_nxt;

    // State and sweep counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // Sweep one address per cycle, leave INIT after the last one
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            ST_INIT: begin
                init_cnt_nxt = init_cnt + A_WIDTH'(1);
                if (init_cnt == A_WIDTH'(DEPTH - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    assign run_c = (state == ST_RUN);
    assign busy  = (state == ST_INIT);
`else
    assign run_c = 1'b1;
    assign busy  = 1'b0;
`endif

    // Round-robin search starting at ptr; only in RUN and out of reset
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        cand_c      = '0;
        found_c     = 1'b0;
        if (run_c && rst_n) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand_c = PTR_W'((32'(ptr) + k) % N_REQ);
                if (!found_c && bus.req_valid[cand_c]) begin
                    found_c         = 1'b1;
                    grant_c[cand_c] = 1'b1;
                    grant_idx_c     = cand_c;
                end
            end
        end
    end

    assign bus.req_ready = grant_c;

    // Payload mux for the granted requester
    always_comb begin
        sel_we_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_c[i]) begin
                sel_we_c    = bus.req_we[i];
                sel_addr_c  = bus.req_addr[i*A_WIDTH +: A_WIDTH];
                sel_wdata_c = bus.req_wdata[i*D_WIDTH +: D_WIDTH];
            end
        end
    end

    // RAM write port: sweep owns it in INIT, granted writer in RUN
    always_comb begin
        ram_we_c    = found_c && sel_we_c;
        ram_waddr_c = sel_addr_c;
        ram_wdata_c = sel_wdata_c;
`ifdef LUTRAM_ARB_INIT_EN
        if (state == ST_INIT && rst_n) begin
            ram_we_c    = 1'b1;
            ram_waddr_c = init_cnt;
            ram_wdata_c = '0;
        end
`endif
    end

    // Unreset distributed RAM array
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram[ram_waddr_c] <= ram_wdata_c;
        end
    end

    // Pointer and registered response; the read sees pre-write contents
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr           <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= grant_c;
            if (found_c) begin
                ptr           <= (grant_idx_c == PTR_W'(N_REQ - 1)) ? '0
                                                                    : grant_idx_c + PTR_W'(1);
                bus.rsp_rdata <= ram[sel_addr_c];
            end
        end
    end
endmodule

// File: tb/tb_lutram_port_arbiter.sv
// tb_lutram_port_arbiter: directed bench for lutram_port_arbiter with
// hand-computed expectations (D_WIDTH=8, A_WIDTH=5, N_REQ=3).
module tb_lutram_port_arbiter;
    localparam int D_WIDTH = 8;
    localparam int A_WIDTH = 5;
    localparam int N_REQ   = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] exp_post_rst;

    always #5 clk = ~clk;

    lutram_port_arbiter_if #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .N_REQ(N_REQ)) bus ();

    lutram_port_arbiter #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .N_REQ(N_REQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [4:0] a, input logic [7:0] d);
        bus.req_valid[i]                     = v;
        bus.req_we[i]                        = we;
        bus.req_addr[i*A_WIDTH +: A_WIDTH]   = a;
        bus.req_wdata[i*D_WIDTH +: D_WIDTH]  = d;
    endtask

    // Check combinational grant, clock, then check the tagged response
    task automatic step(input string tag, input logic [2:0] exp_grant,
                        input logic check_data, input logic [7:0] exp_data);
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(exp_grant));
        @(posedge clk);
        #1;
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_grant));
        if (check_data) chk({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(exp_data));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 1'b0, 5'd0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 32'h0);
`ifdef LUTRAM_ARB_INIT_EN
        chk("rst_busy", 32'(busy), 32'h1);
        exp_post_rst = 8'h00;
`else
        chk("rst_busy", 32'(busy), 32'h0);
        exp_post_rst = 8'h31;
`endif
        rst_n = 1'b1;

`ifdef LUTRAM_ARB_INIT_EN
        // Requests held high: nothing is granted for 32 cycles
        for (int c = 0; c < 32; c++) begin
            #1;
            chk("init_busy", 32'(busy), 32'h1);
            chk("init_ready", 32'(bus.req_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        chk("init_done_busy", 32'(busy), 32'h0);
        bus.req_valid = '0;
        for (int a = 0; a < 32; a++) begin
            set_req(0, 1'b1, 1'b0, 5'(a), 8'h00);
            step("init_zero", 3'b001, 1'b1, 8'h00);
        end
        set_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
`else
        bus.req_valid = '0;
`endif

        // Write then read by req0
        set_req(0, 1'b1, 1'b1, 5'd3, 8'hA5);
        step("wr3", 3'b001, 1'b0, 8'h00);
        set_req(0, 1'b1, 1'b0, 5'd3, 8'h00);
        step("rd3", 3'b001, 1'b1, 8'hA5);
        set_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
        step("idle_hold", 3'b000, 1'b1, 8'hA5);

        // Read-first ack from req2
        set_req(2, 1'b1, 1'b1, 5'd7, 8'h11);
        step("rf_w1", 3'b100, 1'b0, 8'h00);
        set_req(2, 1'b1, 1'b1, 5'd7, 8'h22);
        step("rf_w2", 3'b100, 1'b1, 8'h11);
        set_req(2, 1'b1, 1'b0, 5'd7, 8'h00);
        step("rf_rd", 3'b100, 1'b1, 8'h22);
        set_req(2, 1'b0, 1'b0, 5'd0, 8'h00);

        // Preload addresses 1 and 2
        set_req(1, 1'b1, 1'b1, 5'd1, 8'h31);
        step("w1", 3'b010, 1'b0, 8'h00);
        set_req(1, 1'b0, 1'b0, 5'd0, 8'h00);
        set_req(2, 1'b1, 1'b1, 5'd2, 8'h42);
        step("w2", 3'b100, 1'b0, 8'h00);

        // Saturation, ptr starts at 0
        set_req(0, 1'b1, 1'b0, 5'd1, 8'h00);
        set_req(1, 1'b1, 1'b0, 5'd2, 8'h00);
        set_req(2, 1'b1, 1'b0, 5'd3, 8'h00);
        step("sat0", 3'b001, 1'b1, 8'h31);
        step("sat1", 3'b010, 1'b1, 8'h42);
        step("sat2", 3'b100, 1'b1, 8'hA5);
        step("sat3", 3'b001, 1'b1, 8'h31);
        step("sat4", 3'b010, 1'b1, 8'h42);

        // One-cycle reset mid-stream with ptr at 2
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        rst_n = 1'b1;
`ifdef LUTRAM_ARB_INIT_EN
        repeat (32) @(posedge clk);
        #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
`endif
        step("rst_first", 3'b001, 1'b1, exp_post_rst);

        // Pointer skip with req0 idle, then req0 rejoins
        set_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
        step("ps0", 3'b010, 1'b0, 8'h00);
        step("ps1", 3'b100, 1'b0, 8'h00);
        step("ps2", 3'b010, 1'b0, 8'h00);
        set_req(0, 1'b1, 1'b0, 5'd1, 8'h00);
        step("ps3", 3'b100, 1'b0, 8'h00);
        step("ps4", 3'b001, 1'b1, exp_post_rst);
        bus.req_valid = '0;
        step("final_idle", 3'b000, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
